neighbor_table_update: RTL
==========================

# neighbor_table_update

Upstream of the aggregation-decision stage: folds one received beacon (source ID, cluster ID, sink flag) into the node's shared-memory neighbour and known-sink tables. The decision stage later scans these same tables. The block is a single-port memory master on the same 16-bit word bus: scan for the source, update or append, then do the same for the known-sink list.

## Interface
Parameters:
- MAX_NEIGHBORS, 64: capacity of neighbour table.
- MAX_SINKS, 32: capacity of known-sink table.

Ports:
- clock  in  1  system clock.
- nrst  in  1  reset, synchronous, active-low.
- start  in  1  begin one update; sampled only in IDLE.
- pkt_src_id  in  16  beacon source node ID; captured on accepted start.
- pkt_cluster_id  in  16  beacon cluster ID; captured on accepted start.
- pkt_is_sink  in  1  beacon source is a sink; captured on accepted start.
- data_in  in  16  memory read data.
- address  out  16  memory byte address; words at even addresses.
- wr_en  out  1  write strobe, one cycle per word.
- data_out  out  16  write data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  table full, entry dropped; valid with done, held until next start.

## Operation
- Memory map, fixed: neighbourID[i] at 0x48+2i; clusterID[i] at 0xC8+2i; knownSinks[j] at 0x8+2j; knownSinkCount at 0x688; neighborCount at 0x68A.
- Reads: address is registered. data_in is valid and sampled at the edge after the edge that loaded address.
- States and transitions:
  - IDLE: on start, capture packet fields, clear overflow, address<=0x68A, go to LD_NCNT.
  - LD_NCNT: ncnt<=data_in, address<=0x688.
  - LD_SCNT: scnt<=data_in. If ncnt==0, go to NB_MISS. Otherwise i<=0, address<=0x48, go to NB_SCAN.
  - NB_SCAN: one entry per cycle.
    - If data_in==src: go to NB_HIT.
    - Otherwise i<=i+1. If i+1==ncnt, go to NB_MISS; else address<=0x48+2(i+1).
  - NB_HIT: write cluster ID to 0xC8+2i. Then go to SINK.
  - NB_MISS: if ncnt>=MAX_NEIGHBORS, set overflow and go to SINK. Otherwise do three consecutive single-cycle writes:
    - src to 0x48+2·ncnt;
    - cluster to 0xC8+2·ncnt;
    - ncnt+1 to 0x68A.
  - SINK: if !is_sink, go to FIN. If scnt==0, go to SK_MISS. Otherwise scan 0x8+2j the same way as NB_SCAN; a hit goes to FIN.
  - SK_MISS: if scnt>=MAX_SINKS, set overflow and go to FIN. Otherwise write src to 0x8+2·scnt, then write scnt+1 to 0x688.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Counts read from memory are saturated at the MAX parameter before use. Index arithmetic is 16-bit; address=base+(index<<1).
- An existing neighbour's cluster ID is always rewritten, even when unchanged.
- start while busy is ignored.

## Timing
- Reset values: state IDLE; address 0x0000; wr_en 0; data_out 0x0000; busy 0; done 0; overflow 0.
- Reset mid-operation aborts immediately. A write already strobed stays committed; no further writes occur.
- wr_en, address and data_out change together at one edge. wr_en never stays high for more than one cycle.
- Latency, from the start edge to the done-high cycle:
  - 3 cycles of count loads;
  - plus k+1 cycles for a neighbour hit at index k, or ncnt cycles for a miss;
  - plus 1 write cycle (hit) or 3 write cycles (append);
  - plus the same pattern for the sink phase when is_sink (append = 2 writes);
  - plus 1 cycle for FIN.
- Back-to-back: a start in the cycle after done is accepted.

## Structure
- Shared package holds the memory-map constants: NBR_ID_BASE 0x48, CLUSTER_ID_BASE 0xC8, KNOWN_SINK_BASE 0x8, KNOWN_SINK_CNT 0x688, NBR_CNT 0x68A, FLAG_AGG 0x2. It also holds the word width (16) and the state enum. The aggregation-decision stage imports the same constants.
- One sub-module is natural: table_scan. It takes base, count and key and produces hit, index and address, and is instantiated once and reused for both tables.

## Test plan
- Empty tables, start with src=5, cluster=2, is_sink=0:
  - writes 0x48←5, 0xC8←2, 0x68A←1;
  - done at cycle 7 after start;
  - overflow=0.
- Table {3,5,9}, clusters {1,1,4}, src=5, cluster=7, is_sink=0:
  - exactly one write, 0xCA←7;
  - neighborCount unchanged.
- ncnt=64, unknown src:
  - no neighbour writes;
  - overflow=1 with done.
- Sink path:
  - knownSinks {8}, scnt=1, src=12, is_sink=1, new neighbour: 0xA←12 and 0x688←2 after the neighbour append.
  - Repeat with src=8: no sink writes.
- Protocol edges:
  - nrst low during NB_SCAN: outputs return to reset values next edge; no writes follow.
  - start held high during busy: ignored, one done only.

Source files
------------

// File: rtl/neighbor_table_update_pkg.sv
// Shared memory map, word width and state encoding for the beacon table-update path.
// The aggregation-decision stage imports the same constants.
package neighbor_table_update_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] KNOWN_SINK_BASE = 16'h0008;
    localparam logic [WORD_W-1:0] NBR_ID_BASE     = 16'h0048;
    localparam logic [WORD_W-1:0] CLUSTER_ID_BASE = 16'h00C8;
    localparam logic [WORD_W-1:0] KNOWN_SINK_CNT  = 16'h0688;
    localparam logic [WORD_W-1:0] NBR_CNT         = 16'h068A;
    localparam logic [WORD_W-1:0] FLAG_AGG        = 16'h0002;

    typedef enum logic [3:0] {
        StIdle,
        StLdNcnt,
        StLdScnt,
        StNbScan,
        StNbHit,
        StNbMiss,
        StSink,
        StSkScan,
        StSkMiss,
        StFin
    } state_e;

    // Byte address of 16-bit word idx in a table starting at base.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                    input logic [WORD_W-1:0] idx);
        return base + (idx << 1);
    endfunction

    function automatic logic [WORD_W-1:0] sat_count(input logic [WORD_W-1:0] value,
                                                    input logic [WORD_W-1:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/neighbor_table_update_table_scan.sv
// One step of a linear table scan: compares the current word against the key and
// computes the next index and its address. Shared by the neighbour and sink scans.
module neighbor_table_update_table_scan
    import neighbor_table_update_pkg::*;
(
    input  logic [WORD_W-1:0] base,
    input  logic [WORD_W-1:0] count,
    input  logic [WORD_W-1:0] key,
    input  logic [WORD_W-1:0] data_in,
    input  logic [WORD_W-1:0] index,
    output logic              hit,
    output logic              last,
    output logic [WORD_W-1:0] next_index,
    output logic [WORD_W-1:0] next_address
);

    always_comb begin
        next_index   = index + 16'd1;
        hit          = (data_in == key);
        last         = (next_index == count);
        next_address = word_addr(base, next_index);
    end

endmodule

// File: rtl/neighbor_table_update.sv
// Folds one received beacon into the shared-memory neighbour and known-sink tables
// by scanning each table and either rewriting the hit entry or appending a new one.
module neighbor_table_update
    import neighbor_table_update_pkg::*;
#(
    parameter int unsigned MAX_NEIGHBORS = 64,
    parameter int unsigned MAX_SINKS     = 32
) (
    input  logic              clock,
    input  logic              nrst,
    input  logic              start,
    input  logic [WORD_W-1:0] pkt_src_id,
    input  logic [WORD_W-1:0] pkt_cluster_id,
    input  logic              pkt_is_sink,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] address,
    output logic              wr_en,
    output logic [WORD_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [WORD_W-1:0] MAX_NB = 16'(MAX_NEIGHBORS);
    localparam logic [WORD_W-1:0] MAX_SK = 16'(MAX_SINKS);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] src_q, src_d, cluster_q, cluster_d;
    logic              is_sink_q, is_sink_d;
    logic [WORD_W-1:0] ncnt_q, ncnt_d, scnt_q, scnt_d, idx_q, idx_d;
    logic [1:0]        wstep_q, wstep_d;
    logic [WORD_W-1:0] address_q, address_d, data_out_q, data_out_d;
    logic              wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

    logic [WORD_W-1:0] scan_base, scan_count, scan_next_idx, scan_next_addr;
    logic              scan_hit, scan_last;

    always_comb begin
        scan_base  = (state_q == StSkScan) ? KNOWN_SINK_BASE : NBR_ID_BASE;
        scan_count = (state_q == StSkScan) ? scnt_q : ncnt_q;
    end

    neighbor_table_update_table_scan u_scan (
        .base         (scan_base),
        .count        (scan_count),
        .key          (src_q),
        .data_in      (data_in),
        .index        (idx_q),
        .hit          (scan_hit),
        .last         (scan_last),
        .next_index   (scan_next_idx),
        .next_address (scan_next_addr)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cluster_d  = cluster_q;
        is_sink_d  = is_sink_q;
        ncnt_d     = ncnt_q;
        scnt_d     = scnt_q;
        idx_d      = idx_q;
        wstep_d    = wstep_q;
        address_d  = address_q;
        data_out_d = data_out_q;
        wr_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d     = pkt_src_id;
                    cluster_d = pkt_cluster_id;
                    is_sink_d = pkt_is_sink;
                    ovf_d     = 1'b0;
                    busy_d    = 1'b1;
                    address_d = NBR_CNT;
                    state_d   = StLdNcnt;
                end
            end
            StLdNcnt: begin
                ncnt_d    = sat_count(data_in, MAX_NB);
                address_d = KNOWN_SINK_CNT;
                state_d   = StLdScnt;
            end
            StLdScnt: begin
                scnt_d  = sat_count(data_in, MAX_SK);
                wstep_d = 2'd0;
                if (ncnt_q == '0) begin
                    state_d = StNbMiss;
                end else begin
                    idx_d     = '0;
                    address_d = NBR_ID_BASE;
                    state_d   = StNbScan;
                end
            end
            StNbScan: begin
                if (scan_hit) begin
                    state_d = StNbHit;
                end else begin
                    idx_d = scan_next_idx;
                    if (scan_last) state_d = StNbMiss;
                    else           address_d = scan_next_addr;
                end
            end
            StNbHit: begin
                wr_en_d    = 1'b1;
                address_d  = word_addr(CLUSTER_ID_BASE, idx_q);
                data_out_d = cluster_q;
                state_d    = StSink;
            end
            StNbMiss: begin
                if (ncnt_q >= MAX_NB) begin
                    ovf_d   = 1'b1;
                    state_d = StSink;
                end else begin
                    wr_en_d = 1'b1;
                    wstep_d = wstep_q + 2'd1;
                    case (wstep_q)
                        2'd0: begin
                            address_d  = word_addr(NBR_ID_BASE, ncnt_q);
                            data_out_d = src_q;
                        end
                        2'd1: begin
                            address_d  = word_addr(CLUSTER_ID_BASE, ncnt_q);
                            data_out_d = cluster_q;
                        end
                        default: begin
                            address_d  = NBR_CNT;
                            data_out_d = ncnt_q + 16'd1;
                            wstep_d    = 2'd0;
                            state_d    = StSink;
                        end
                    endcase
                end
            end
            StSink: begin
                wstep_d = 2'd0;
                if (!is_sink_q) begin
                    state_d = StFin;
                end else if (scnt_q == '0) begin
                    state_d = StSkMiss;
                end else begin
                    idx_d     = '0;
                    address_d = KNOWN_SINK_BASE;
                    state_d   = StSkScan;
                end
            end
            StSkScan: begin
                if (scan_hit) begin
                    state_d = StFin;
                end else begin
                    idx_d = scan_next_idx;
                    if (scan_last) state_d = StSkMiss;
                    else           address_d = scan_next_addr;
                end
            end
            StSkMiss: begin
                if (scnt_q >= MAX_SK) begin
                    ovf_d   = 1'b1;
                    state_d = StFin;
                end else if (wstep_q == 2'd0) begin
                    wr_en_d    = 1'b1;
                    address_d  = word_addr(KNOWN_SINK_BASE, scnt_q);
                    data_out_d = src_q;
                    wstep_d    = 2'd1;
                end else begin
                    wr_en_d    = 1'b1;
                    address_d  = KNOWN_SINK_CNT;
                    data_out_d = scnt_q + 16'd1;
                    wstep_d    = 2'd0;
                    state_d    = StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q    <= StIdle;
            src_q      <= '0;
            cluster_q  <= '0;
            is_sink_q  <= 1'b0;
            ncnt_q     <= '0;
            scnt_q     <= '0;
            idx_q      <= '0;
            wstep_q    <= 2'd0;
            address_q  <= '0;
            data_out_q <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cluster_q  <= cluster_d;
            is_sink_q  <= is_sink_d;
            ncnt_q     <= ncnt_d;
            scnt_q     <= scnt_d;
            idx_q      <= idx_d;
            wstep_q    <= wstep_d;
            address_q  <= address_d;
            data_out_q <= data_out_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign address  = address_q;
    assign wr_en    = wr_en_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
